react_timer: RTL and testbench

Timing datapath that feeds the reaction-test state machine. It tracks the 3-bit machine state and produces the four inputs that machine needs: the random pre-stimulus delay expiry (`signal_start`), the counter-cleared acknowledge (`signal_cleared`), the measurement timeout (`signal_overflow`) and the millisecond reaction count (`react_time`). It also drives the "go" stimulus indicator.

---
 rtl/react_timer_pkg.sv | 65 ++++++
 rtl/react_timer_lfsr.sv | 39 +++
 rtl/react_timer.sv | 192 +++++++++++++++++++
 tb/tb_react_timer.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/react_timer_pkg.sv
// -----------------------------------------------------------------------------
// react_timer_pkg
// Shared definitions for the reaction-timer datapath:
//   - 3-bit state codes driven by the reaction-test state machine
//   - internal timer mode enum
//   - LFSR tap masks (x^11+x^9+1 for the production width)
//   - binary-to-BCD helper used when REACT_TIMER_BCD_EN is defined
// -----------------------------------------------------------------------------
package react_timer_pkg;

    // State codes as produced by the reaction-test state machine
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT     = 3'd1;
    localparam logic [2:0] ST_CLR_CNT1 = 3'd2;
    localparam logic [2:0] ST_START    = 3'd3;
    localparam logic [2:0] ST_STORAGE  = 3'd4;
    localparam logic [2:0] ST_CLR_CNT2 = 3'd5;
    localparam logic [2:0] ST_AVERAGE  = 3'd6;
    localparam logic [2:0] ST_COMPARE  = 3'd7;

    // Internal timer modes, decoded from the machine state every cycle
    typedef enum logic [2:0] {
        T_IDLE,
        T_DELAY,
        T_CLEAR,
        T_RUN,
        T_HOLD
    } mode_t;

    // x^11 + x^9 + 1 : feedback from bits 10 and 8 of a shift-left register
    localparam logic [10:0] LFSR_TAPS_11 = 11'h500;

    // Maximal-length tap masks for the widths the timer may be built with.
    // Unlisted widths fall back to the 11-bit polynomial.
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            3:       return 32'h0000_0006;  // x^3+x^2+1
            4:       return 32'h0000_000C;  // x^4+x^3+1
            5:       return 32'h0000_0014;  // x^5+x^3+1
            6:       return 32'h0000_0030;  // x^6+x^5+1
            7:       return 32'h0000_0060;  // x^7+x^6+1
            8:       return 32'h0000_00B8;  // x^8+x^6+x^5+x^4+1
            9:       return 32'h0000_0110;  // x^9+x^5+1
            10:      return 32'h0000_0240;  // x^10+x^7+1
            12:      return 32'h0000_0829;  // x^12+x^6+x^4+x+1
            default: return {21'd0, LFSR_TAPS_11};
        endcase
    endfunction

    // Double-dabble conversion of a 10-bit count into four BCD digits
    function automatic logic [15:0] bin2bcd(input logic [9:0] bin);
        logic [25:0] sh;
        sh = {16'd0, bin};
        for (int i = 0; i < 10; i++) begin
            for (int d = 0; d < 4; d++) begin
                if (sh[10 + 4*d +: 4] >= 4'd5) begin
                    sh[10 + 4*d +: 4] = sh[10 + 4*d +: 4] + 4'd3;
                end
            end
            sh = sh << 1;
        end
        return sh[25:10];
    endfunction

endpackage

// File: rtl/react_timer_lfsr.sv
// -----------------------------------------------------------------------------
// lfsr_rand
// Free-running Fibonacci LFSR. Shifts left every clock; the XOR of the tapped
// bits is fed into bit 0. Restarts from a fixed nonzero seed on reset.
// Ports:
//   clk   - system clock
//   rstn  - asynchronous active-low reset
//   value - current LFSR contents (WIDTH bits, never zero)
// -----------------------------------------------------------------------------
module lfsr_rand
    import react_timer_pkg::*;
#(
    parameter int               WIDTH = 11,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_taps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rstn,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] lfsr_reg;
    logic [WIDTH-1:0] lfsr_next;

    always_comb begin
        lfsr_next = {lfsr_reg[WIDTH-2:0], ^(lfsr_reg & TAPS)};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr_reg <= SEED;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    assign value = lfsr_reg;

endmodule

// File: rtl/react_timer.sv
// -----------------------------------------------------------------------------
// react_timer
// Timing datapath for the reaction-test state machine: random pre-stimulus
// delay, counter-clear acknowledge, millisecond reaction counter with
// saturation/overflow, and the "go" light.
// Optional feature macro: REACT_TIMER_BCD_EN adds react_time_bcd.
// Ports:
//   clk             - system clock
//   rstn            - asynchronous active-low reset
//   machine_state   - 3-bit state code from the state machine
//   signal_start    - one-cycle pulse when the random delay expires
//   signal_cleared  - counters are zero while in a CLR state
//   signal_overflow - START count has reached MAX_MS
//   react_time      - elapsed milliseconds (bits [15:10] always 0)
//   led_go          - stimulus light, high while in START
//   react_time_bcd  - (REACT_TIMER_BCD_EN only) react_time as 4 BCD digits,
//                     one cycle behind react_time
// -----------------------------------------------------------------------------
module react_timer
    import react_timer_pkg::*;
#(
    parameter int TICKS_PER_MS = 50000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 11,
    parameter int MAX_MS       = 999
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [2:0]  machine_state,
    output logic        signal_start,
    output logic        signal_cleared,
    output logic        signal_overflow,
    output logic [15:0] react_time,
    output logic        led_go
`ifdef REACT_TIMER_BCD_EN
    ,
    output logic [15:0] react_time_bcd
`endif
);

    localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    // One spare bit so MIN_DELAY_MS + (2^RAND_BITS - 1) always fits
    localparam int DW = $clog2(MIN_DELAY_MS + 2**RAND_BITS) + 1;

    localparam logic [PW-1:0] TICK_LAST = PW'(TICKS_PER_MS - 1);
    localparam logic [9:0]    MAX_CNT   = 10'(MAX_MS);
    localparam logic [DW-1:0] MIN_LOAD  = DW'(MIN_DELAY_MS);

    logic [RAND_BITS-1:0] lfsr_val;

    logic [2:0]    prev_state_reg;
    logic [PW-1:0] presc_reg,    presc_next;
    logic [9:0]    ms_reg,       ms_next;
    logic [DW-1:0] delay_reg,    delay_next;
    logic          armed_reg,    armed_next;
    logic          start_reg,    start_next;
    logic          cleared_reg,  cleared_next;
    logic          overflow_reg, overflow_next;
    logic          led_go_reg,   led_go_next;

    mode_t         mode;
    logic          entry;
    logic          tick;
    logic [PW-1:0] presc_eff;
    logic [PW-1:0] presc_wrap;
    logic [DW-1:0] delay_load;

    lfsr_rand #(
        .WIDTH (RAND_BITS)
    ) u_lfsr (
        .clk   (clk),
        .rstn  (rstn),
        .value (lfsr_val)
    );

    always_comb begin
        mode = T_HOLD;
        case (machine_state)
            ST_IDLE:                  mode = T_IDLE;
            ST_WAIT:                  mode = T_DELAY;
            ST_CLR_CNT1, ST_CLR_CNT2: mode = T_CLEAR;
            ST_START:                 mode = T_RUN;
            ST_STORAGE, ST_AVERAGE,
            ST_COMPARE:               mode = T_HOLD;
            default:                  mode = T_HOLD;
        endcase
    end

    always_comb begin
        entry      = (machine_state != prev_state_reg);
        // The prescaler restarts from 0 on every state entry, so both the
        // delay and the run count are measured from the entry edge.
        presc_eff  = entry ? '0 : presc_reg;
        tick       = (presc_eff == TICK_LAST);
        presc_wrap = tick ? '0 : presc_eff + PW'(1);
        delay_load = MIN_LOAD + {{(DW-RAND_BITS){1'b0}}, lfsr_val};

        presc_next    = presc_reg;
        ms_next       = ms_reg;
        delay_next    = delay_reg;
        armed_next    = 1'b0;
        start_next    = 1'b0;
        cleared_next  = 1'b0;
        overflow_next = 1'b0;
        led_go_next   = 1'b0;

        case (mode)
            T_IDLE: begin
                presc_next = '0;
                ms_next    = '0;
                delay_next = '0;
            end
            T_DELAY: begin
                presc_next = presc_wrap;
                if (entry) begin
                    delay_next = delay_load;
                    armed_next = 1'b1;
                end else begin
                    if (tick && (delay_reg != '0)) begin
                        delay_next = delay_reg - DW'(1);
                    end
                    // armed limits the pulse to one per WAIT visit; leaving
                    // WAIT drops it, which abandons a pending delay.
                    start_next = armed_reg && (delay_reg == '0);
                    armed_next = armed_reg && (delay_reg != '0);
                end
            end
            T_CLEAR: begin
                presc_next   = '0;
                ms_next      = '0;
                cleared_next = !entry;
            end
            T_RUN: begin
                presc_next  = presc_wrap;
                led_go_next = 1'b1;
                if (tick && (ms_reg != MAX_CNT)) begin
                    ms_next = ms_reg + 10'd1;
                end
                overflow_next = (ms_next == MAX_CNT);
            end
            T_HOLD: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_state_reg <= ST_IDLE;
            presc_reg      <= '0;
            ms_reg         <= '0;
            delay_reg      <= '0;
            armed_reg      <= 1'b0;
            start_reg      <= 1'b0;
            cleared_reg    <= 1'b0;
            overflow_reg   <= 1'b0;
            led_go_reg     <= 1'b0;
        end else begin
            prev_state_reg <= machine_state;
            presc_reg      <= presc_next;
            ms_reg         <= ms_next;
            delay_reg      <= delay_next;
            armed_reg      <= armed_next;
            start_reg      <= start_next;
            cleared_reg    <= cleared_next;
            overflow_reg   <= overflow_next;
            led_go_reg     <= led_go_next;
        end
    end

    assign signal_start    = start_reg;
    assign signal_cleared  = cleared_reg;
    assign signal_overflow = overflow_reg;
    assign react_time      = {6'd0, ms_reg};
    assign led_go          = led_go_reg;

`ifdef REACT_TIMER_BCD_EN
    logic [15:0] bcd_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bcd_reg <= 16'h0000;
        end else begin
            bcd_reg <= bin2bcd(ms_reg);
        end
    end

    assign react_time_bcd = bcd_reg;
`endif

endmodule

// File: tb/tb_react_timer.sv
// -----------------------------------------------------------------------------
// tb_react_timer
// Self-checking bench for react_timer with small timing parameters.
// Optional macro REACT_TIMER_BCD_EN enables the BCD output scenario.
// -----------------------------------------------------------------------------
module tb_react_timer;

    localparam int TPM   = 4;
    localparam int MIN_D = 2;
    localparam int RB    = 3;
    localparam int MAXC  = 9;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_CLR1  = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_STORE = 3'd4;
    localparam logic [2:0] S_CLR2  = 3'd5;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [2:0]  machine_state = S_IDLE;
    logic        signal_start, signal_cleared, signal_overflow, led_go;
    logic [15:0] react_time;

    int errors = 0;
    int checks = 0;
    int edges  = 0;
    logic [RB-1:0] lfsr_seq [7];

    always #5 clk = ~clk;

    // Edges seen since reset release: the LFSR has advanced exactly this many times
    always @(posedge clk or negedge rstn) begin
        if (!rstn) edges <= 0;
        else       edges <= edges + 1;
    end

`ifdef REACT_TIMER_BCD_EN
    logic        b_start, b_cleared, b_overflow, b_led_go;
    logic [15:0] b_react_time, b_react_bcd, react_time_bcd;
    logic [2:0]  b_state = S_IDLE;

    react_timer #(
        .TICKS_PER_MS (TPM), .MIN_DELAY_MS (MIN_D), .RAND_BITS (RB), .MAX_MS (999)
    ) dut_bcd (
        .clk             (clk),
        .rstn            (rstn),
        .machine_state   (b_state),
        .signal_start    (b_start),
        .signal_cleared  (b_cleared),
        .signal_overflow (b_overflow),
        .react_time      (b_react_time),
        .led_go          (b_led_go),
        .react_time_bcd  (b_react_bcd)
    );
`endif

    react_timer #(
        .TICKS_PER_MS (TPM), .MIN_DELAY_MS (MIN_D), .RAND_BITS (RB), .MAX_MS (MAXC)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .machine_state   (machine_state),
        .signal_start    (signal_start),
        .signal_cleared  (signal_cleared),
        .signal_overflow (signal_overflow),
        .react_time      (react_time),
        .led_go          (led_go)
`ifdef REACT_TIMER_BCD_EN
        ,
        .react_time_bcd  (react_time_bcd)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sequence of x^3+x^2+1 starting from the seed 1
    task automatic build_lfsr_seq();
        logic [RB-1:0] s;
        s = 3'b001;
        for (int i = 0; i < 7; i++) begin
            lfsr_seq[i] = s;
            s = {s[1:0], s[2] ^ s[1]};
        end
    endtask

    task automatic test_reset();
        int bad;
        rstn = 1'b0;
        machine_state = S_IDLE;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({signal_start, signal_cleared, signal_overflow, led_go, react_time} !== 20'd0) begin
            errors++;
            $display("FAIL reset_in: outputs=%h required=0",
                     {signal_start, signal_cleared, signal_overflow, led_go, react_time});
        end
        rstn = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if ({signal_start, signal_cleared, signal_overflow, led_go, react_time} !== 20'd0) begin
                errors++;
                bad++;
                $display("FAIL idle_hold cycle %0d: outputs=%h required=0", i,
                         {signal_start, signal_cleared, signal_overflow, led_go, react_time});
            end
        end
        $display("reset + 20 idle cycles: bad cycles=%0d", bad);
    endtask

    // want >= 0 : wait for that LFSR value before entering WAIT; else random
    task automatic test_wait(input int want, input int pre);
        int val, expk, firstk, pulses, rbad;
        machine_state = S_IDLE;
        step();
        repeat (pre) step();
        if (want >= 0) begin
            for (int i = 0; i < 7 && int'(lfsr_seq[edges % 7]) != want; i++) step();
        end
        val  = int'(lfsr_seq[edges % 7]);
        expk = (MIN_D + val) * TPM + 1;
        machine_state = S_WAIT;
        firstk = 0; pulses = 0; rbad = 0;
        for (int k = 1; k <= expk + 40; k++) begin
            step();
            if (signal_start === 1'b1) begin
                pulses++;
                if (firstk == 0) firstk = k;
            end
            if (react_time !== 16'd0) rbad++;
        end
        checks++;
        if (want >= 0 && val != want) begin
            errors++;
            $display("FAIL wait_lfsr: model value=%0d required=%0d", val, want);
        end
        checks++;
        if (firstk != expk) begin
            errors++;
            $display("FAIL start_time: pulse at cycle %0d required %0d", firstk, expk);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL start_count: pulses=%0d required=1", pulses);
        end
        checks++;
        if (rbad != 0) begin
            errors++;
            $display("FAIL wait_react_hold: %0d cycles nonzero, required 0", rbad);
        end
        $display("wait: lfsr=%0d delay=%0d ms pulse@%0d expected@%0d pulses=%0d",
                 val, MIN_D + val, firstk, expk, pulses);
        machine_state = S_IDLE;
        step();
    endtask

    task automatic test_abandon();
        int n, pulses;
        machine_state = S_IDLE;
        step();
        n = $urandom_range(1, 10);
        machine_state = S_WAIT;
        pulses = 0;
        repeat (n) begin
            step();
            if (signal_start === 1'b1) pulses++;
        end
        machine_state = S_CLR1;
        repeat (40) begin
            step();
            if (signal_start === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL abandon: pulses=%0d required=0", pulses);
        end
        $display("abandon: left WAIT after %0d cycles, pulses=%0d", n, pulses);
        test_wait(-1, $urandom_range(0, 6));
    endtask

    task automatic test_run(input int n, input logic [2:0] clr);
        int e, bad;
        machine_state = clr;
        repeat (2) step();
        machine_state = S_START;
        bad = 0;
        e = 0;
        for (int j = 1; j <= n; j++) begin
            step();
            e = (j / TPM > MAXC) ? MAXC : j / TPM;
            checks++;
            if (react_time !== 16'(e) || led_go !== 1'b1 ||
                signal_overflow !== (e == MAXC)) begin
                errors++;
                bad++;
                $display("FAIL run cycle %0d: react=%0d led=%b ovf=%b required react=%0d led=1 ovf=%0d",
                         j, react_time, led_go, signal_overflow, e, (e == MAXC));
            end
        end
        machine_state = S_STORE;
        repeat (2) begin
            step();
            checks++;
            if (react_time !== 16'(e) || led_go !== 1'b0 || signal_overflow !== 1'b0) begin
                errors++;
                $display("FAIL storage_hold: react=%0d led=%b ovf=%b required react=%0d led=0 ovf=0",
                         react_time, led_go, signal_overflow, e);
            end
        end
        $display("run: %0d START cycles -> react=%0d (expected %0d), bad cycles=%0d",
                 n, react_time, e, bad);
    endtask

    task automatic test_clear();
        int sbad;
        test_run(24, S_CLR2);
        machine_state = S_WAIT;
        sbad = 0;
        repeat (5) begin
            step();
            checks++;
            if (react_time !== 16'd6 || signal_start !== 1'b0) begin
                errors++;
                sbad++;
                $display("FAIL wait_hold6: react=%0d start=%b required react=6 start=0",
                         react_time, signal_start);
            end
        end
        machine_state = S_CLR1;
        step();
        checks++;
        if (react_time !== 16'd0 || signal_cleared !== 1'b0) begin
            errors++;
            $display("FAIL clear_first: react=%0d cleared=%b required react=0 cleared=0",
                     react_time, signal_cleared);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (signal_cleared !== 1'b1 || react_time !== 16'd0) begin
                errors++;
                $display("FAIL clear_level %0d: cleared=%b react=%0d required cleared=1 react=0",
                         i, signal_cleared, react_time);
            end
        end
        machine_state = S_STORE;
        step();
        checks++;
        if (signal_cleared !== 1'b0) begin
            errors++;
            $display("FAIL clear_exit: cleared=%b required 0", signal_cleared);
        end
        $display("clear: react 6 -> 0, cleared asserted from second CLR cycle, hold errors=%0d", sbad);
    endtask

    task automatic test_async_reset();
        machine_state = S_CLR2;
        repeat (2) step();
        machine_state = S_START;
        repeat (12) step();
        checks++;
        if (react_time !== 16'd3) begin
            errors++;
            $display("FAIL pre_reset: react=%0d required 3", react_time);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({signal_start, signal_cleared, signal_overflow, led_go, react_time} !== 20'd0) begin
            errors++;
            $display("FAIL async_reset: outputs=%h required=0",
                     {signal_start, signal_cleared, signal_overflow, led_go, react_time});
        end
        machine_state = S_IDLE;
        @(posedge clk);
        #1 rstn = 1'b1;
        step();
        checks++;
        if ({signal_start, signal_cleared, signal_overflow, led_go, react_time} !== 20'd0) begin
            errors++;
            $display("FAIL post_reset: outputs=%h required=0",
                     {signal_start, signal_cleared, signal_overflow, led_go, react_time});
        end
        $display("async reset mid-START: react 3 -> 0 without a clock edge");
        // LFSR must have restarted from its seed for the model to line up
        test_wait(-1, $urandom_range(0, 6));
    endtask

`ifdef REACT_TIMER_BCD_EN
    function automatic logic [15:0] dec_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic test_bcd();
        b_state = S_CLR1;
        repeat (2) step();
        b_state = S_START;
        repeat (537 * TPM) step();
        checks++;
        if (b_react_time !== 16'd537 || b_react_bcd !== dec_bcd(536)) begin
            errors++;
            $display("FAIL bcd_lag: react=%0d bcd=%h required react=537 bcd=%h",
                     b_react_time, b_react_bcd, dec_bcd(536));
        end
        b_state = S_STORE;
        step();
        checks++;
        if (b_react_time !== 16'd537 || b_react_bcd !== dec_bcd(537)) begin
            errors++;
            $display("FAIL bcd_value: react=%0d bcd=%h required react=537 bcd=%h",
                     b_react_time, b_react_bcd, dec_bcd(537));
        end
        checks++;
        if (react_time_bcd !== dec_bcd(int'(react_time))) begin
            errors++;
            $display("FAIL bcd_main: bcd=%h required %h", react_time_bcd, dec_bcd(int'(react_time)));
        end
        $display("bcd: count 537 -> bcd=%h", b_react_bcd);
    endtask
`endif

    initial begin
        build_lfsr_seq();
        test_reset();
        test_wait(5, 0);
        for (int i = 0; i < 3; i++) test_wait(-1, $urandom_range(0, 13));
        test_abandon();
        test_clear();
        test_run(18, S_CLR1);
        test_run(60, S_CLR2);
        test_run($urandom_range(5, 45), S_CLR1);
        test_async_reset();
`ifdef REACT_TIMER_BCD_EN
        test_bcd();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
